// File: rtl/spi_slave.sv
// SPI mode-0 slave, 8-bit LSB-first frames, with double-buffered transmit.
// All pins are synchronized into the clk domain before use.
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_busy,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       rx_read,
    output logic       overrun,
    output logic       sel
);

    typedef enum logic {IDLE, XFER} state_e;

    state_e state_q, state_d;

    // [0],[1] synchronize, [2] holds the previous level for edge detection
    logic [2:0] sck_q, ss_q, mosi_q;

    logic sck_rise_q, sck_fall_q;
    logic ss_rise_q, ss_fall_q;
    logic mosi_bit_q;

    logic [2:0] cnt_q;
    logic [7:0] rx_sh_q, tx_sh_q, tx_buf_q;
    logic [7:0] rx_data_q;
    logic       tx_busy_q, rx_rdy_q, overrun_q;

    logic enter, leave, active;
    logic rx_bit, tx_fall, done, tx_reload;

    // Pin synchronizers, idle levels on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= 3'b000;
            ss_q   <= 3'b111;
            mosi_q <= 3'b000;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            ss_q   <= {ss_q[1:0], ss};
            mosi_q <= {mosi_q[1:0], mosi};
        end
    end

    // Registered edge events; mosi delayed to stay aligned with sck
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            ss_rise_q  <= 1'b0;
            ss_fall_q  <= 1'b0;
            mosi_bit_q <= 1'b0;
        end else begin
            sck_rise_q <= sck_q[1] & ~sck_q[2];
            sck_fall_q <= ~sck_q[1] & sck_q[2];
            ss_rise_q  <= ss_q[1] & ~ss_q[2];
            ss_fall_q  <= ~ss_q[1] & ss_q[2];
            mosi_bit_q <= mosi_q[1];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: select edges open and close a transfer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ss_fall_q) state_d = XFER;
            XFER: if (ss_rise_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: miso idles high outside a transfer
    always_comb begin
        sel  = (state_q == XFER);
        miso = (state_q == XFER) ? tx_sh_q[0] : 1'b1;
    end

    // Datapath qualifiers; sck edges only count inside a transfer
    always_comb begin
        enter     = (state_q == IDLE) && ss_fall_q;
        leave     = (state_q == XFER) && ss_rise_q;
        active    = (state_q == XFER) && !ss_rise_q;
        rx_bit    = active && sck_rise_q;
        tx_fall   = active && sck_fall_q;
        done      = rx_bit && (cnt_q == 3'd7);
        tx_reload = enter || (tx_fall && (cnt_q == 3'd0));
    end

    // Transmit buffer and shifter; a reload drains the buffer or sends 0xFF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf_q  <= 8'h00;
            tx_busy_q <= 1'b0;
            tx_sh_q   <= 8'h00;
        end else begin
            if (tx_load) begin
                tx_buf_q  <= tx_data;
                tx_busy_q <= 1'b1;
            end else if (tx_reload && tx_busy_q) begin
                tx_busy_q <= 1'b0;
            end
            if (leave)
                tx_sh_q <= 8'h00;
            else if (tx_reload)
                tx_sh_q <= tx_busy_q ? tx_buf_q : 8'hFF;
            else if (tx_fall)
                tx_sh_q <= {1'b0, tx_sh_q[7:1]};
        end
    end

    // Receive shifter, bit counter and the handshake to the host side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 3'd0;
            rx_sh_q   <= 8'h00;
            rx_data_q <= 8'h00;
            rx_rdy_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (enter || leave) begin
                cnt_q   <= 3'd0;
                rx_sh_q <= 8'h00;
            end else if (rx_bit) begin
                cnt_q          <= cnt_q + 3'd1;
                rx_sh_q[cnt_q] <= mosi_bit_q;
            end
            if (done) begin
                rx_data_q <= {mosi_bit_q, rx_sh_q[6:0]};
                rx_rdy_q  <= 1'b1;
                if (rx_rdy_q && !rx_read) overrun_q <= 1'b1;
            end else if (rx_read) begin
                rx_rdy_q <= 1'b0;
            end
        end
    end

    assign tx_busy = tx_busy_q;
    assign rx_data = rx_data_q;
    assign rx_rdy  = rx_rdy_q;
    assign overrun = overrun_q;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; all logic is clocked on the rising edge of clk.
REQ-002 SHALL expose these ports:
  clk      in   1  system clock
  rst_n    in   1  asynchronous reset, active-low
  sck      in   1  SPI clock from master, asynchronous to clk
  ss       in   1  slave select, active-low, asynchronous
  mosi     in   1  master-out serial data
  miso     out  1  slave-out serial data
  tx_data  in   8  byte to transmit
  tx_load  in   1  one-cycle strobe; writes tx_data into tx buffer
  tx_busy  out  1  tx buffer holds a byte not yet moved to the shifter
  rx_data  out  8  last complete received byte
  rx_rdy   out  1  rx_data valid and unread
  rx_read  in   1  one-cycle strobe; acknowledges rx_data
  overrun  out  1  sticky; byte completed while rx_rdy was high
  sel      out  1  synchronized select, high while transfer active

Function
REQ-003 SHALL implement SPI mode 0: mosi sampled on sck rising edge, miso changed on sck falling edge, 8-bit frames, LSB first.
REQ-004 SHALL pass sck, ss and mosi through a 2-flop synchronizer plus one edge-detect register each, all with identical depth.
REQ-005 SHALL act on a pin event exactly 3 clk rising edges after the first clk edge that captures the new pin level.
REQ-006 SHALL require sck high and low phases >= 4 clk periods each, and ss-low to first sck rise >= 4 clk periods; behaviour outside this is unspecified.
REQ-007 SHALL use FSM states IDLE and XFER; IDLE->XFER on synchronized ss falling edge; XFER->IDLE on synchronized ss rising edge.
REQ-008 SHALL, on entry to XFER and after each 8th falling sck edge while ss is low, load the tx shifter from the tx buffer if tx_busy=1 (then clear tx_busy), else load 0xFF.
REQ-009 SHALL drive miso = shifter bit 0 in XFER, updated on the same cycle as the load; shift right by one on each synchronized sck falling edge.
REQ-010 SHALL drive miso = 1 in IDLE.
REQ-011 SHALL shift synchronized mosi into rx shifter bit [count] on each synchronized sck rising edge and increment a 3-bit bit counter that wraps 7->0.
REQ-012 SHALL, on the rising edge that completes bit 7: copy the shifter to rx_data, set rx_rdy, and set overrun if rx_rdy was already 1 (new data overwrites).
REQ-013 SHALL clear rx_rdy on the cycle after rx_read=1; if rx_read and byte completion coincide, rx_rdy stays 1 with the new byte and overrun is not set.
REQ-014 SHALL clear overrun only by reset.
REQ-015 SHALL accept tx_load in any state; tx_load while tx_busy=1 overwrites the buffer; tx_load coinciding with shifter load loads the old buffer and leaves the new byte buffered (tx_busy stays 1).
REQ-016 SHALL, on ss rising mid-byte: reset the bit counter, discard partial rx bits without asserting rx_rdy, and discard the partial tx byte; the tx buffer is kept.
REQ-017 SHALL drive sel = 1 exactly while the FSM is in XFER.
REQ-018 SHALL ignore sck edges while in IDLE.

Reset
REQ-019 SHALL, while rst_n=0, force: FSM=IDLE, miso=1, tx_busy=0, rx_data=0x00, rx_rdy=0, overrun=0, sel=0, bit counter=0, shifters=0, synchronizers=idle levels (sck=0, ss=1, mosi=0).
REQ-020 SHALL, when rst_n is asserted mid-transfer, return to IDLE immediately and require a fresh ss falling edge before shifting resumes.

Verification
REQ-021 Reset: rst_n low for 3 clk then high, pins idle -> miso=1, rx_rdy=0, tx_busy=0, overrun=0, sel=0, rx_data=0x00.
REQ-022 Receive: master sends 0xAA LSB-first with ss low -> rx_data=0xAA, rx_rdy=1 until one rx_read, then 0 next cycle.
REQ-023 Transmit: tx_load 0x5A before ss falls -> tx_busy=1 then 0 at ss fall; miso at successive sck rises = 0,1,0,1,1,0,1,0.
REQ-024 Underrun and multi-byte: no tx_load, two bytes 0x11, 0x22 with ss held low, no rx_read -> miso sends 0xFF twice, rx_data=0x22, overrun=1.
REQ-025 Abort: ss rises after 5 sck rises -> no rx_rdy, sel=0; next full byte 0x3C -> rx_data=0x3C, rx_rdy=1.
REQ-026 Reset mid-byte: rst_n low after 4 bits -> all REQ-019 values; following full transfer of 0xC3 -> rx_data=0xC3.
